max_scan_ctrl: RTL and testbench
================================

# max_scan_ctrl

Sequential controller that streams a burst of 4-bit unsigned values through the team's existing 4-bit greater-than comparator and reports the largest value and its position. It sits between a value source (valid/ready stream) and downstream logic that needs a max/argmax result. It owns the comparator's sequencing: it selects the operands, updates a running maximum and signals completion.

## Interface

Parameters:
- DATA_W, 4, element width; fixed by the comparator and not overridable in practice.
- IDX_W, 4, width of `len` and `max_idx`. Maximum burst length is 2^IDX_W−1 = 15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a burst; sampled only in IDLE.
- len  input  IDX_W  number of elements in the burst, sampled with `start`.
- in_valid  input  1  `in_data` is valid.
- in_ready  output  1  controller accepts an element this cycle.
- in_data  input  DATA_W  element value, unsigned.
- busy  output  1  high from the cycle after `start` is accepted through the DONE cycle.
- done  output  1  one-cycle pulse; results are valid.
- max_val  output  DATA_W  largest value in the burst.
- max_idx  output  IDX_W  0-based position of the first occurrence of `max_val`.

## Operation

- States: IDLE, SCAN, DONE.
- IDLE:
  - `in_ready`=0 and `busy`=0.
  - When `start`=1: latch `len`, clear `max_val`, `max_idx` and the element counter `cnt` to 0.
  - If `len`≠0, go to SCAN; if `len`=0, go to DONE.
- SCAN:
  - `in_ready`=1.
  - An element is accepted on a cycle where `in_valid`&&`in_ready`.
  - First element (`cnt`=0): loaded unconditionally. `max_val`←`in_data`, `max_idx`←0.
  - Later elements: the comparator evaluates `in_data` > `max_val`. If true, `max_val`←`in_data` and `max_idx`←`cnt`. Otherwise both hold.
  - Comparison is strict, so on ties the earliest index wins.
  - `cnt` increments on every accept.
  - When the accepted element is number `len` (`cnt`==`len`−1), go to DONE.
  - Cycles with `in_valid`=0 (bubbles) change nothing.
- DONE:
  - `done`=1, `busy`=1, `in_ready`=0.
  - Go to IDLE unconditionally on the next edge.
- Results: `max_val` and `max_idx` hold their final values after DONE until the next accepted `start`.
- `start` while not in IDLE is ignored. It is not queued.
- `len`=0: result is `max_val`=0 and `max_idx`=0.
- `cnt` never wraps, because `len`≤15 bounds it.
- Reset (any time, including mid-burst):
  - State→IDLE.
  - `in_ready`, `busy`, `done`, `max_val`, `max_idx` and `cnt` all go to 0.
  - A partially scanned burst is discarded.

## Timing

- Reset values: every output is 0.
- Start → first accept: `start` accepted at edge T. State is SCAN at T+1, so `in_ready`=1 in cycle T+1.
- Throughput: one element per cycle with no bubbles.
- Latency: last element accepted at edge E. `done`=1 for exactly cycle E+1. `in_ready`=1 again no earlier than cycle E+3 (IDLE at E+2, earliest new start at E+2).
- Minimum burst time: `len`+2 cycles from the `start` edge to the return to IDLE.
- `len`=0: `done` is asserted in the cycle after `start` is accepted.
- Comparator path: combinational within one cycle (`in_data` and `max_val` to the register enable). No pipeline stage.

## Structure

- Shared package `max_scan_pkg`:
  - `DATA_W` and `IDX_W` constants.
  - State enum `{S_IDLE, S_SCAN, S_DONE}`, 2-bit encoding.
- One sub-module instance: `four_bit_greater_than`, with inputs `a`=`in_data` and `b`=`max_val`. Its output feeds the update enable.
- No other hierarchy. Counter, registers and FSM are in this module.

## Test plan

- Basic: `len`=4, stream 3, 9, 9, 2 with no bubbles → `done` in the cycle after the 4th accept, `max_val`=9, `max_idx`=1 (tie keeps the first).
- Bubbles and full length: `len`=15, stream 0..14 ascending, with `in_valid` low every other cycle → `max_val`=14, `max_idx`=14. `done` occurs only after the 15th accept. `in_ready` stays high throughout SCAN.
- Degenerate lengths:
  - `len`=0 → `done` one cycle after `start`, outputs 0, `in_ready` never asserted.
  - `len`=1 with value 0 → `max_val`=0, `max_idx`=0.
- Ignored start: assert `start` with `len`=2 while in SCAN of a `len`=3 burst 5, 1, 7 → the result is 7 at index 2. No second `done` follows.
- Reset mid-burst: deassert `rst_n` after 2 of 5 elements → all outputs 0 immediately (asynchronous). A fresh burst `len`=2 of 15, 4 afterwards → `max_val`=15, `max_idx`=0.
- Result hold: after `done`, idle for 10 cycles with `in_valid` toggling → `max_val`/`max_idx` unchanged and `in_ready`=0 until the next `start`.

Source files
------------

// File: rtl/max_scan_pkg.sv
// rtl/max_scan_pkg.sv - shared constants and state encoding for the max/argmax scan controller
//
// Purpose : element/index widths and the controller state enum, shared by
//           max_scan_ctrl and anything that needs to decode its state.
// Ports   : none (package).

package max_scan_pkg;

  // Element width is pinned by the 4-bit comparator.
  localparam int DATA_W = 4;
  // Index/length width; longest burst is 2**IDX_W - 1 elements.
  localparam int IDX_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage : max_scan_pkg

// File: rtl/four_bit_greater_than.sv
// rtl/four_bit_greater_than.sv - unsigned 4-bit magnitude comparator
//
// Purpose : combinational a > b for two 4-bit unsigned operands.
// Ports   : a  [3:0] in   left operand
//           b  [3:0] in   right operand
//           gt       out  1 when a > b (unsigned)

module four_bit_greater_than (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       gt
);

  always_comb begin
    gt = (a > b);
  end

endmodule : four_bit_greater_than

// File: rtl/max_scan_ctrl.sv
// rtl/max_scan_ctrl.sv - streams a burst of 4-bit values and reports max value and first index
//
// Purpose : accepts `len` elements from a valid/ready source, keeps a running
//           maximum using the 4-bit comparator, and pulses `done` when the
//           result is final. Results hold until the next accepted start.
// Ports   : clk       in   clock, rising edge
//           rst_n     in   asynchronous active-low reset
//           start     in   begin a burst (sampled in IDLE only)
//           len       in   burst length, sampled with start
//           in_valid  in   in_data valid
//           in_ready  out  element accepted this cycle when in_valid is high
//           in_data   in   element value, unsigned
//           busy      out  high from the cycle after start through DONE
//           done      out  one-cycle result-valid pulse
//           max_val   out  largest value seen in the burst
//           max_idx   out  0-based index of the first occurrence of max_val

module max_scan_ctrl #(
  parameter int DATA_W = max_scan_pkg::DATA_W,
  parameter int IDX_W  = max_scan_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] max_val,
  output logic [IDX_W-1:0]  max_idx
);

  import max_scan_pkg::*;

  state_e            state_q,   state_d;
  logic [IDX_W-1:0]  len_q,     len_d;
  logic [IDX_W-1:0]  cnt_q,     cnt_d;
  logic [DATA_W-1:0] max_val_q, max_val_d;
  logic [IDX_W-1:0]  max_idx_q, max_idx_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;

  logic              gt;
  logic              accept;
  logic              last_elem;

  // Comparator sees the incoming element against the running maximum; its
  // output gates the max register update in the same cycle.
  four_bit_greater_than u_gt (
    .a  (in_data),
    .b  (max_val_q),
    .gt (gt)
  );

  // in_ready_q is high exactly while in SCAN, so it doubles as the accept qualifier.
  assign accept    = in_valid && in_ready_q;
  assign last_elem = (cnt_q == (len_q - IDX_W'(1)));

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d     = len;
          cnt_d     = '0;
          max_val_d = '0;
          max_idx_d = '0;
          state_d   = (len == '0) ? S_DONE : S_SCAN;
        end
      end

      S_SCAN: begin
        if (accept) begin
          // First element loads unconditionally; later ones only on a strict
          // win so ties keep the earliest index.
          if (cnt_q == '0) begin
            max_val_d = in_data;
            max_idx_d = '0;
          end else if (gt) begin
            max_val_d = in_data;
            max_idx_d = cnt_q;
          end
          cnt_d = cnt_q + IDX_W'(1);
          if (last_elem) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered: decode them from the next state.
    in_ready_d = (state_d == S_SCAN);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      max_val_q  <= '0;
      max_idx_q  <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      max_val_q  <= max_val_d;
      max_idx_q  <= max_idx_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign max_val  = max_val_q;
  assign max_idx  = max_idx_q;

endmodule : max_scan_ctrl

// File: tb/tb_max_scan_ctrl.sv
// tb/tb_max_scan_ctrl.sv - self-checking bench for max_scan_ctrl

module tb_max_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       busy;
  logic       done;
  logic [3:0] max_val;
  logic [3:0] max_idx;

  max_scan_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .busy     (busy),
    .done     (done),
    .max_val  (max_val),
    .max_idx  (max_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          len;
    logic [59:0] vals;   // element i in vals[4*i +: 4]
    int          bmode;  // 0: no bubbles, 1: valid every other cycle, 2: random
    int          exp_max;
    int          exp_idx;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: max of the burst and the first position where it occurs.
  task automatic ref_max(input int l, input logic [59:0] vals, output int m, output int idx);
    m   = 0;
    idx = 0;
    for (int i = 0; i < l; i++) begin
      if (int'(vals[4*i +: 4]) > m) begin
        m   = int'(vals[4*i +: 4]);
        idx = i;
      end
    end
  endtask

  // Issues start from IDLE, streams the burst and checks handshake, timing and result.
  task automatic run_burst(input int l, input logic [59:0] vals, input int bmode,
                           input int em, input int ei);
    int acc = 0;
    int cyc = 0;
    bit v;
    start    = 1'b1;
    len      = 4'(l);
    in_valid = 1'b0;
    step();
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("in_ready_after_start", int'(in_ready), int'(l != 0));
    if (l != 0) begin
      while (acc < l && cyc < 64) begin
        case (bmode)
          0:       v = 1'b1;
          1:       v = (cyc % 2 == 0);
          default: v = ($urandom_range(0, 2) != 0);
        endcase
        in_valid = v;
        in_data  = v ? vals[4*acc +: 4] : 4'($urandom);
        chk("scan_in_ready", int'(in_ready), 1);
        chk("scan_done_early", int'(done), 0);
        step();
        if (v) acc++;
        cyc++;
      end
      if (acc < l) chk("burst_timeout", acc, l);
      in_valid = 1'b0;
    end
    chk("done_pulse", int'(done), 1);
    chk("done_busy", int'(busy), 1);
    chk("done_in_ready", int'(in_ready), 0);
    chk("max_val", int'(max_val), em);
    chk("max_idx", int'(max_idx), ei);
    step();
    chk("idle_done", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_in_ready", int'(in_ready), 0);
    chk("hold_max_val", int'(max_val), em);
    chk("hold_max_idx", int'(max_idx), ei);
  endtask

  initial begin
    int m;
    int idx;
    logic [59:0] rv;

    tbl[0] = '{4,  60'h2993,           0, 9,  1};
    tbl[1] = '{15, 60'hEDCBA9876543210, 1, 14, 14};
    tbl[2] = '{0,  60'h0,              0, 0,  0};
    tbl[3] = '{1,  60'h0,              0, 0,  0};
    tbl[4] = '{3,  60'h715,            0, 7,  2};
    tbl[5] = '{2,  60'h4F,             1, 15, 0};
    tbl[6] = '{5,  60'h88888,          2, 8,  0};
    tbl[7] = '{3,  60'hF21,            0, 15, 2};

    rst_n    = 1'b0;
    start    = 1'b0;
    len      = 4'd0;
    in_valid = 1'b0;
    in_data  = 4'd0;
    step();
    step();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_max_val", int'(max_val), 0);
    chk("rst_max_idx", int'(max_idx), 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      run_burst(tbl[i].len, tbl[i].vals, tbl[i].bmode, tbl[i].exp_max, tbl[i].exp_idx);
    end

    // start during SCAN is ignored: len=3 burst 5,1,7 with start/len=2 on the first accept
    start = 1'b1;
    len   = 4'd3;
    step();
    in_valid = 1'b1;
    in_data  = 4'd5;
    len      = 4'd2;
    step();
    start   = 1'b0;
    in_data = 4'd1;
    step();
    chk("ign_no_early_done", int'(done), 0);
    in_data = 4'd7;
    step();
    in_valid = 1'b0;
    chk("ign_done", int'(done), 1);
    chk("ign_max_val", int'(max_val), 7);
    chk("ign_max_idx", int'(max_idx), 2);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ign_no_second_done", int'(done), 0);
      chk("ign_idle_busy", int'(busy), 0);
    end

    // results hold across idle cycles with in_valid toggling
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 4'($urandom);
      step();
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_done", int'(done), 0);
      chk("hold_val", int'(max_val), 7);
      chk("hold_idx", int'(max_idx), 2);
    end
    in_valid = 1'b0;

    // asynchronous reset after 2 of 5 elements
    start = 1'b1;
    len   = 4'd5;
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'd9;
    step();
    in_data = 4'd12;
    step();
    in_valid = 1'b0;
    chk("pre_rst_max_val", int'(max_val), 12);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", int'(in_ready), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_max_val", int'(max_val), 0);
    chk("arst_max_idx", int'(max_idx), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", int'(in_ready), 0);
    run_burst(2, 60'h4F, 0, 15, 0);

    // randomized bursts against the reference
    for (int n = 0; n < 40; n++) begin
      int l;
      int gap;
      l  = $urandom_range(0, 15);
      rv = '0;
      for (int i = 0; i < 15; i++) begin
        rv[4*i +: 4] = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      end
      ref_max(l, rv, m, idx);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'($urandom);
        in_data  = 4'($urandom);
        len      = 4'($urandom);
        step();
        chk("rnd_gap_in_ready", int'(in_ready), 0);
        chk("rnd_gap_busy", int'(busy), 0);
      end
      in_valid = 1'b0;
      run_burst(l, rv, $urandom_range(0, 2), m, idx);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_max_scan_ctrl
